// File: rtl/alu_result_skid.sv
// EX-to-WB boundary: 2-entry skid buffer for ALU results with zero/sign/parity flags captured on entry.
// Define ALU_RES_STALL_CNT_EN to add a saturating writeback-stall counter output.
module alu_result_skid #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_par
`ifdef ALU_RES_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              zero;
    logic              neg;
    logic              par;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} cnt_e;

  cnt_e   cnt, cnt_nxt;
  entry_t head, skid, in_ent;
  logic   push, pop, head_ld, head_from_skid, skid_ld;

  // Flags travel with the entry so WB never re-derives them from out_data.
  always_comb begin
    in_ent      = '0;
    in_ent.data = in_data;
    in_ent.rd   = in_rd;
    in_ent.zero = (in_data == '0);
    in_ent.neg  = in_data[DATA_W-1];
    in_ent.par  = ^in_data;
  end

  assign out_valid = (cnt != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    cnt_nxt        = cnt;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush) begin
      cnt_nxt = EMPTY;
    end else begin
      case (cnt)
        EMPTY: if (push) begin
          cnt_nxt = ONE;
          head_ld = 1'b1;
        end
        ONE: begin
          if (push && pop) begin
            head_ld = 1'b1;
          end else if (push) begin
            cnt_nxt = FULL;
            skid_ld = 1'b1;
          end else if (pop) begin
            cnt_nxt = EMPTY;
          end
        end
        FULL: if (pop) begin
          cnt_nxt        = ONE;
          head_ld        = 1'b1;
          head_from_skid = 1'b1;
        end
        default: cnt_nxt = EMPTY;
      endcase
    end
  end

  // in_ready comes from a flop so there is no combinational path from out_ready into EX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= EMPTY;
      in_ready <= 1'b1;
      head     <= '0;
      skid     <= '0;
    end else begin
      cnt      <= cnt_nxt;
      in_ready <= (cnt_nxt != FULL);
      if (head_ld) head <= head_from_skid ? skid : in_ent;
      if (skid_ld) skid <= in_ent;
    end
  end

  assign out_data = head.data;
  assign out_rd   = head.rd;
  assign out_zero = head.zero;
  assign out_neg  = head.neg;
  assign out_par  = head.par;

`ifdef ALU_RES_STALL_CNT_EN
  // Survives flush on purpose: it measures WB backpressure, not pipeline contents.
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_result_skid.sv
// Scoreboard bench for alu_result_skid: directed plan items then randomized traffic vs a queue model.
module tb_alu_result_skid;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_rd, out_rd;
  logic        out_zero, out_neg, out_par;
`ifdef ALU_RES_STALL_CNT_EN
  logic [15:0] stall_cnt;
  int          exp_stall = 0;
`endif

  always #5 clk = ~clk;

  alu_result_skid dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_zero(out_zero), .out_neg(out_neg), .out_par(out_par)
`ifdef ALU_RES_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        z, n, p;
  } ent_t;

  ent_t q[$];
  ent_t last;
  bit   started = 0;
  int   checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] d, input logic [4:0] rd);
    ent_t e;
    e.d  = d;
    e.rd = rd;
    e.z  = (d == 32'd0);
    e.n  = (d >= 32'h8000_0000);
    e.p  = ($countones(d) % 2) == 1;
    return e;
  endfunction

  // Monitor + model: compare visible state, then apply the effect of the coming rising edge.
  always @(negedge clk) begin
    ent_t exp_e;
    bit   do_push, do_pop;
    if (started) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      exp_e = (q.size() > 0) ? q[0] : last;
      chk("out_data", out_data, exp_e.d);
      chk("out_rd", out_rd, exp_e.rd);
      chk("out_zero", out_zero, exp_e.z);
      chk("out_neg", out_neg, exp_e.n);
      chk("out_par", out_par, exp_e.p);
`ifdef ALU_RES_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, exp_stall);
`endif
      if (q.size() > 0) last = q[0];
    end
    if (!rst_n) begin
      q.delete();
      last    = '{32'd0, 5'd0, 1'b0, 1'b0, 1'b0};
      started = 1;
`ifdef ALU_RES_STALL_CNT_EN
      exp_stall = 0;
`endif
    end else if (started) begin
`ifdef ALU_RES_STALL_CNT_EN
      if (q.size() > 0 && !out_ready && exp_stall < 16'hFFFF) exp_stall++;
`endif
      do_push = in_valid && (q.size() < 2);
      do_pop  = (q.size() > 0) && out_ready;
      if (flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(mk(in_data, in_rd));
      end
    end
  end

  task automatic step(input logic r, input logic fl, input logic v,
                      input logic [31:0] d, input logic [4:0] rd, input logic ordy);
    rst_n = r; flush = fl; in_valid = v; in_data = d; in_rd = rd; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    a = 32'hA5A5_5A5A;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // Single zero result, then drains.
    step(1, 0, 1, a ^ a, 5'd3, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    // Back-to-back stream.
    step(1, 0, 1, 32'h8000_0001, 5'd1, 1);
    step(1, 0, 1, 32'h0000_0007, 5'd2, 1);
    step(1, 0, 1, 32'hFFFF_FFFF, 5'd4, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    // Backpressure: third push is refused.
    step(1, 0, 1, 32'h11, 5'd5, 0);
    step(1, 0, 1, 32'h22, 5'd6, 0);
    step(1, 0, 1, 32'h33, 5'd7, 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    // Flush while full with a pending push.
    step(1, 0, 1, 32'h66, 5'd8, 0);
    step(1, 0, 1, 32'h77, 5'd9, 0);
    step(1, 1, 1, 32'h44, 5'd10, 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    // Reset while full.
    step(1, 0, 1, 32'h88, 5'd11, 0);
    step(1, 0, 1, 32'h99, 5'd12, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 32'h55, 5'd13, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    // Held entry for 5 stalled cycles, then flush, then reset.
    step(1, 0, 1, 32'hAB, 5'd14, 0);
    repeat (5) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199) != 0, $urandom_range(39) == 0, $urandom_range(99) < 60,
           ($urandom_range(3) == 0) ? 32'd0 : $urandom, 5'($urandom), $urandom_range(99) < 65);
    end
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
